serial_frame_rx: RTL and testbench



---
 rtl/serial_frame_rx.sv | 226 ++++++++++++++++++++++
 tb/tb_serial_frame_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_rx
// Purpose  : Single-line serial frame receiver. Detects a low start bit,
//            shifts in DATA_BITS data bits LSB first, optionally checks a
//            parity bit, checks a high stop bit and reports the word with a
//            one-cycle done strobe.
// Ports    : clk        - rising-edge clock
//            reset      - synchronous, active-high reset
//            in         - serial line, idle high, already synchronised to clk
//            data       - last good word, updates only together with done
//            done       - one-cycle strobe, good frame received
//            err_frame  - one-cycle strobe, stop bit sampled low
//            err_parity - one-cycle strobe, parity mismatch (0 when the
//                         parity option is not compiled in)
// Options  : SERIAL_RX_PARITY_EN - when defined, a parity bit follows the
//            data bits and is checked (even parity, or odd if PARITY_ODD=1).
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_rx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  output logic [DATA_BITS-1:0] data,
  output logic                 done,
  output logic                 err_frame,
  output logic                 err_parity
);

  // Distance from the detect cycle to the start-bit mid-point sample.
  localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF_M1 = CNT_W'((HALF > 0) ? (HALF - 1) : 0);
  localparam logic [BIT_W-1:0] C_LAST    = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_frame_q, err_frame_d;
  logic                 tick;

`ifdef SERIAL_RX_PARITY_EN
  localparam logic C_ODD = 1'(PARITY_ODD);
  logic par_err_q, par_err_d;
  logic err_parity_q, err_parity_d;
`endif

  // A bit is sampled whenever the baud counter has run down to zero.
  assign tick = (baud_q == '0);

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    done_d      = 1'b0;
    err_frame_d = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_err_d    = par_err_q;
    err_parity_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (!in) begin
          bit_d   = '0;
          shift_d = '0;
`ifdef SERIAL_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
          // With HALF==0 the detect cycle doubles as the start-bit sample.
          if (HALF == 0) begin
            state_d = S_DATA;
            baud_d  = C_FULL;
          end else begin
            state_d = S_START;
            baud_d  = C_HALF_M1;
          end
        end
      end

      S_START: begin
        if (tick) begin
          if (in) begin
            state_d = S_IDLE;           // false start, silently dropped
          end else begin
            state_d = S_DATA;
            baud_d  = C_FULL;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      S_DATA: begin
        if (tick) begin
          // Right shift: after DATA_BITS samples the first bit sits at bit 0.
          shift_d = {in, shift_q[DATA_BITS-1:1]};
          baud_d  = C_FULL;
          if (bit_q == C_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

`ifdef SERIAL_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          par_err_d = (in != ((^shift_q) ^ C_ODD));
          state_d   = S_STOP;
          baud_d    = C_FULL;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (tick) begin
          if (in) begin
            state_d = S_IDLE;
`ifdef SERIAL_RX_PARITY_EN
            if (par_err_q) begin
              err_parity_d = 1'b1;
            end else begin
              done_d = 1'b1;
              data_d = shift_q;
            end
`else
            done_d = 1'b1;
            data_d = shift_q;
`endif
          end else begin
            state_d     = S_WAIT_IDLE;
            err_frame_d = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
            err_parity_d = par_err_q;
`endif
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      // A line stuck low after a framing error must not look like a start.
      S_WAIT_IDLE: begin
        if (in) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      err_frame_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_err_q    <= 1'b0;
      err_parity_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      done_q      <= done_d;
      err_frame_q <= err_frame_d;
`ifdef SERIAL_RX_PARITY_EN
      par_err_q    <= par_err_d;
      err_parity_q <= err_parity_d;
`endif
    end
  end

  assign data      = data_q;
  assign done      = done_q;
  assign err_frame = err_frame_q;

`ifdef SERIAL_RX_PARITY_EN
  assign err_parity = err_parity_q;
`else
  // Parity selection has no meaning without a parity bit in the frame.
  logic unused_parity_odd;
  assign unused_parity_odd = 1'(PARITY_ODD);
  assign err_parity        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_rx
// Purpose  : Directed self-checking bench for serial_frame_rx. Three
//            instances (8/1, 8/4 and 12/1 data bits / clocks per bit) share
//            one clock and reset; a selector routes the driven line to one
//            instance while the others see an idle-high line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_frame_rx;

`ifdef SERIAL_RX_PARITY_EN
  localparam int P_BIT = 1;
`else
  localparam int P_BIT = 0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic line  = 1'b1;
  int   sel   = 0;
  int   cyc   = 0;

  logic in_a, in_b, in_c;
  assign in_a = (sel == 0) ? line : 1'b1;
  assign in_b = (sel == 1) ? line : 1'b1;
  assign in_c = (sel == 2) ? line : 1'b1;

  logic [7:0]  data_a, data_b;
  logic [11:0] data_c;
  logic        done_a, done_b, done_c;
  logic        ef_a, ef_b, ef_c;
  logic        ep_a, ep_b, ep_c;

  serial_frame_rx #(.DATA_BITS(8), .CLKS_PER_BIT(1), .PARITY_ODD(0)) u_a (
    .clk(clk), .reset(reset), .in(in_a), .data(data_a),
    .done(done_a), .err_frame(ef_a), .err_parity(ep_a));

  serial_frame_rx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_ODD(0)) u_b (
    .clk(clk), .reset(reset), .in(in_b), .data(data_b),
    .done(done_b), .err_frame(ef_b), .err_parity(ep_b));

  serial_frame_rx #(.DATA_BITS(12), .CLKS_PER_BIT(1), .PARITY_ODD(0)) u_c (
    .clk(clk), .reset(reset), .in(in_c), .data(data_c),
    .done(done_c), .err_frame(ef_c), .err_parity(ep_c));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: counts every high cycle and remembers when it was seen.
  logic [2:0] dn, ef, ep;
  assign dn = {done_c, done_b, done_a};
  assign ef = {ef_c, ef_b, ef_a};
  assign ep = {ep_c, ep_b, ep_a};

  int n_done[3], prev_done[3], last_done[3];
  int n_ef[3], last_ef[3];
  int n_ep[3], last_ep[3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (dn[k]) begin
        n_done[k]++;
        prev_done[k] = last_done[k];
        last_done[k] = cyc;
      end
      if (ef[k]) begin
        n_ef[k]++;
        last_ef[k] = cyc;
      end
      if (ep[k]) begin
        n_ep[k]++;
        last_ep[k] = cyc;
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic b, input int n);
    repeat (n) begin
      @(negedge clk);
      line = b;
    end
  endtask

`ifdef SERIAL_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  // Drives start, data (LSB first), optional parity, stop. sc returns the
  // cycle index of the posedge that sees the first start-bit cycle.
  task automatic send(input int db, input int cpb, input logic [15:0] w,
                      input logic stop, output int sc);
`ifdef SERIAL_RX_PARITY_EN
    logic p;
    p = par_flip;
`endif
    @(negedge clk);
    line = 1'b0;
    sc   = cyc;
    repeat (cpb - 1) @(negedge clk);
    for (int i = 0; i < db; i++) begin
      drive(w[i], cpb);
`ifdef SERIAL_RX_PARITY_EN
      p = p ^ w[i];
`endif
    end
`ifdef SERIAL_RX_PARITY_EN
    drive(p, cpb);
`endif
    drive(stop, cpb);
  endtask

  // Cycle on which a strobe is visible: one clock after the stop sample.
  function automatic int exp_cyc(input int sc, input int db, input int cpb);
    return sc + (cpb - 1) / 2 + (db + 1 + P_BIT) * cpb + 1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sc, sc2, nd, ne, np;

    repeat (3) @(negedge clk);
    chk("reset_data_a", 32'(data_a), 32'h0);
    chk("reset_data_c", 32'(data_c), 32'h0);
    chk("reset_strobes_a", {29'd0, done_a, ef_a, ep_a}, 32'h0);
    reset = 1'b0;
    drive(1'b1, 2);

    // Default configuration, good frame 0x55.
    sel = 0;
    nd = n_done[0]; ne = n_ef[0];
    send(8, 1, 16'h0055, 1'b1, sc);
    drive(1'b1, 3);
    chk("t1_done_count", 32'(n_done[0] - nd), 32'd1);
    chk("t1_done_cycle", 32'(last_done[0]), 32'(exp_cyc(sc, 8, 1)));
    chk("t1_done_cycle_abs", 32'(last_done[0] - sc), 32'(10 + P_BIT));
    chk("t1_data", 32'(data_a), 32'h55);
    chk("t1_no_ferr", 32'(n_ef[0] - ne), 32'd0);

    // Framing error, then line held low two extra cycles.
    nd = n_done[0]; ne = n_ef[0]; np = n_ep[0];
    send(8, 1, 16'h0000, 1'b0, sc);
    drive(1'b0, 2);
    drive(1'b1, 3);
    chk("t2_ferr_count", 32'(n_ef[0] - ne), 32'd1);
    chk("t2_ferr_cycle", 32'(last_ef[0]), 32'(exp_cyc(sc, 8, 1)));
    chk("t2_no_done", 32'(n_done[0] - nd), 32'd0);
    chk("t2_no_perr", 32'(n_ep[0] - np), 32'd0);
    chk("t2_data_kept", 32'(data_a), 32'h55);
    nd = n_done[0]; ne = n_ef[0];
    send(8, 1, 16'h0055, 1'b1, sc);
    drive(1'b1, 3);
    chk("t2_next_done_count", 32'(n_done[0] - nd), 32'd1);
    chk("t2_next_done_cycle", 32'(last_done[0]), 32'(exp_cyc(sc, 8, 1)));
    chk("t2_next_no_ferr", 32'(n_ef[0] - ne), 32'd0);

    // CLKS_PER_BIT=4: glitch rejection, then frame 0xA3.
    sel = 1;
    nd = n_done[1]; ne = n_ef[1];
    drive(1'b0, 1);
    drive(1'b1, 12);
    chk("t3_glitch_no_done", 32'(n_done[1] - nd), 32'd0);
    chk("t3_glitch_no_ferr", 32'(n_ef[1] - ne), 32'd0);
    send(8, 4, 16'h00A3, 1'b1, sc);
    drive(1'b1, 3);
    chk("t3_done_count", 32'(n_done[1] - nd), 32'd1);
    chk("t3_done_cycle", 32'(last_done[1]), 32'(exp_cyc(sc, 8, 4)));
    chk("t3_data", 32'(data_b), 32'hA3);

    // DATA_BITS=12: back-to-back frames, second start in the done cycle.
    sel = 2;
    nd = n_done[2]; ne = n_ef[2];
    send(12, 1, 16'h0ABC, 1'b1, sc);
    send(12, 1, 16'h0123, 1'b1, sc2);
    drive(1'b1, 3);
    chk("t4_done_count", 32'(n_done[2] - nd), 32'd2);
    chk("t4_first_cycle", 32'(prev_done[2]), 32'(exp_cyc(sc, 12, 1)));
    chk("t4_second_cycle", 32'(last_done[2]), 32'(exp_cyc(sc2, 12, 1)));
    chk("t4_data", 32'(data_c), 32'h123);
    chk("t4_no_ferr", 32'(n_ef[2] - ne), 32'd0);

    // Reset in the middle of the data bits of the default instance.
    sel = 0;
    nd = n_done[0]; ne = n_ef[0];
    drive(1'b0, 1);
    drive(1'b1, 1);
    drive(1'b0, 1);
    drive(1'b1, 1);
    @(negedge clk);
    reset = 1'b1;
    line  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_reset_data", 32'(data_a), 32'h0);
    chk("t5_reset_strobes", {29'd0, done_a, ef_a, ep_a}, 32'h0);
    drive(1'b1, 3);
    send(8, 1, 16'h000F, 1'b1, sc);
    drive(1'b1, 3);
    chk("t5_done_count", 32'(n_done[0] - nd), 32'd1);
    chk("t5_done_cycle", 32'(last_done[0]), 32'(exp_cyc(sc, 8, 1)));
    chk("t5_data", 32'(data_a), 32'h0F);
    chk("t5_no_ferr", 32'(n_ef[0] - ne), 32'd0);

`ifdef SERIAL_RX_PARITY_EN
    // Even parity: correct parity bit, then a flipped one.
    nd = n_done[0]; np = n_ep[0];
    par_flip = 1'b0;
    send(8, 1, 16'h0055, 1'b1, sc);
    drive(1'b1, 3);
    chk("t6_good_done", 32'(n_done[0] - nd), 32'd1);
    chk("t6_good_data", 32'(data_a), 32'h55);
    chk("t6_good_no_perr", 32'(n_ep[0] - np), 32'd0);
    nd = n_done[0];
    par_flip = 1'b1;
    send(8, 1, 16'h00AA, 1'b1, sc);
    drive(1'b1, 3);
    par_flip = 1'b0;
    chk("t6_bad_perr_count", 32'(n_ep[0] - np), 32'd1);
    chk("t6_bad_perr_cycle", 32'(last_ep[0]), 32'(exp_cyc(sc, 8, 1)));
    chk("t6_bad_no_done", 32'(n_done[0] - nd), 32'd0);
    chk("t6_bad_data_kept", 32'(data_a), 32'h55);
`else
    chk("t6_no_perr_ever", 32'(n_ep[0] + n_ep[1] + n_ep[2]), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
